// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage MIPS core: Tuse/Tnew stall detection,
// D/E-stage forwarding selects and multiply/divide busy sequencing.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [4:0] A3_D,
    input  logic       RegWrite_D,
    input  logic [1:0] Tuse_Rs_D,
    input  logic [1:0] Tuse_Rt_D,
    input  logic [1:0] Tnew_D,
    input  logic       md_op_D,
    input  logic       md_start_D,
    input  logic       md_div_D,
    output logic       stall,
    output logic       flush_E,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       md_busy
);

    logic [4:0] r_A3_E, r_rs_E, r_rt_E, r_A3_M, r_A3_W;
    logic [1:0] r_Tnew_E, r_Tnew_M;
    logic [3:0] r_md_cnt;

    logic [4:0] w_dest;
    logic       w_hz_rs, w_hz_rt, w_md_hz, w_stall;

    function automatic logic reg_hazard(
        input logic [4:0] x, input logic [1:0] tuse,
        input logic [4:0] a_e, input logic [1:0] t_e,
        input logic [4:0] a_m, input logic [1:0] t_m
    );
        return (x != '0) && (tuse != 2'd3) &&
               (((x == a_e) && (tuse < t_e)) || ((x == a_m) && (tuse < t_m)));
    endfunction

    // Slots with A3=0 are empty; a nonzero x therefore never matches them.
    function automatic logic [1:0] fwd_sel_d(
        input logic [4:0] x,
        input logic [4:0] a_e, input logic [1:0] t_e,
        input logic [4:0] a_m, input logic [1:0] t_m,
        input logic [4:0] a_w
    );
        if (x == '0)                         return 2'd0;
        else if ((x == a_e) && (t_e == '0))  return 2'd1;
        else if ((x == a_m) && (t_m == '0))  return 2'd2;
        else if (x == a_w)                   return 2'd3;
        else                                 return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_sel_e(
        input logic [4:0] x,
        input logic [4:0] a_m, input logic [1:0] t_m,
        input logic [4:0] a_w
    );
        if (x == '0)                         return 2'd0;
        else if ((x == a_m) && (t_m == '0))  return 2'd2;
        else if (x == a_w)                   return 2'd3;
        else                                 return 2'd0;
    endfunction

    always_comb begin
        w_dest   = (RegWrite_D && (A3_D != '0)) ? A3_D : '0;
        w_hz_rs  = reg_hazard(rs_D, Tuse_Rs_D, r_A3_E, r_Tnew_E, r_A3_M, r_Tnew_M);
        w_hz_rt  = reg_hazard(rt_D, Tuse_Rt_D, r_A3_E, r_Tnew_E, r_A3_M, r_Tnew_M);
        w_md_hz  = md_op_D && (r_md_cnt != '0);
        w_stall  = w_hz_rs || w_hz_rt || w_md_hz;
    end

    always_comb begin
        stall    = w_stall;
        flush_E  = w_stall;
        md_busy  = (r_md_cnt != '0);
        fwd_rs_D = fwd_sel_d(rs_D, r_A3_E, r_Tnew_E, r_A3_M, r_Tnew_M, r_A3_W);
        fwd_rt_D = fwd_sel_d(rt_D, r_A3_E, r_Tnew_E, r_A3_M, r_Tnew_M, r_A3_W);
        fwd_rs_E = fwd_sel_e(r_rs_E, r_A3_M, r_Tnew_M, r_A3_W);
        fwd_rt_E = fwd_sel_e(r_rt_E, r_A3_M, r_Tnew_M, r_A3_W);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_A3_E   <= '0;
            r_Tnew_E <= '0;
            r_rs_E   <= '0;
            r_rt_E   <= '0;
            r_A3_M   <= '0;
            r_Tnew_M <= '0;
            r_A3_W   <= '0;
            r_md_cnt <= '0;
        end else begin
            if (w_stall) begin
                r_A3_E   <= '0;
                r_Tnew_E <= '0;
                r_rs_E   <= '0;
                r_rt_E   <= '0;
            end else begin
                r_A3_E   <= w_dest;
                r_Tnew_E <= Tnew_D;
                r_rs_E   <= rs_D;
                r_rt_E   <= rt_D;
            end
            r_A3_M   <= r_A3_E;
            r_Tnew_M <= (r_Tnew_E == '0) ? '0 : r_Tnew_E - 2'd1;
            r_A3_W   <= r_A3_M;
            // A start held in D by a stall must not load; the countdown keeps running.
            if (md_start_D && !w_stall)
                r_md_cnt <= md_div_D ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            else if (r_md_cnt != '0)
                r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

endmodule
